// File: rtl/rr_arbiter_4_pkg.sv
// Shared definitions for the four-way round-robin arbiter.
//   state_t   : arbiter FSM encoding (2 bits)
//   N_REQ     : number of requesters
//   rr_pick() : rotating-priority scan, returns index of first set request
//               starting at ptr and wrapping modulo N_REQ
package arb_pkg;

   localparam int N_REQ = 4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT   = 2'd1,
      RECOVER = 2'd2
   } state_t;

   // Caller only uses the result when req != 0; with no request set the
   // returned index is ptr.
   function automatic logic [1:0] rr_pick(input logic [N_REQ-1:0] req,
                                          input logic [1:0]       ptr);
      logic [1:0] idx;
      logic       found;
      rr_pick = ptr;
      found   = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         idx = ptr + 2'(i);
         if (!found && req[idx]) begin
            rr_pick = idx;
            found   = 1'b1;
         end
      end
   endfunction

endpackage

// File: rtl/rr_arbiter_4_if.sv
// Requester-side bus of the round-robin arbiter.
//   req      : per-requester level request
//   grant    : one-hot grant
//   grant_id : index of current/last grant (qualify with busy)
//   busy     : a grant is active
//   timeout  : one-cycle pulse when a grant is revoked by the hold limit
// master = requester side, slave = arbiter side.
interface rr_arbiter_4_if;
   import arb_pkg::*;

   logic [N_REQ-1:0] req;
   logic [N_REQ-1:0] grant;
   logic [1:0]       grant_id;
   logic             busy;
   logic             timeout;

   modport master (output req, input grant, grant_id, busy, timeout);
   modport slave  (input req, output grant, grant_id, busy, timeout);

endinterface

// File: rtl/rr_arbiter_4_decoder.sv
// decoder_2to4: enabled 2-to-4 one-hot decoder.
//   a_i  : select MSB
//   b_i  : select LSB
//   en_i : enable; all outputs low when deasserted
//   y_o  : one-hot output, y_o[i] is Y{i}
module decoder_2to4 (
   input  logic       a_i,
   input  logic       b_i,
   input  logic       en_i,
   output logic [3:0] y_o
);

   always_comb begin
      y_o = 4'b0000;
      if (en_i) begin
         case ({a_i, b_i})
            2'b00:   y_o = 4'b0001;
            2'b01:   y_o = 4'b0010;
            2'b10:   y_o = 4'b0100;
            default: y_o = 4'b1000;
         endcase
      end
   end

endmodule

// File: rtl/rr_arbiter_4.sv
// rr_arbiter_4: four-way round-robin arbiter with grant hold limit.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : rr_arbiter_4_if.slave (req in; grant, grant_id, busy, timeout out)
// Parameters: MAX_HOLD (2..255) cycles a grant may stay asserted;
//             CNT_W derived hold counter width, do not override.
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | no grant; arbitrate among pending requests
// GRANT   | grant_id owns the resource; hold counter running
// RECOVER | one dead cycle after a revoke, timeout pulse is high
module rr_arbiter_4
   import arb_pkg::*;
#(
   parameter int MAX_HOLD = 16,
   parameter int CNT_W    = $clog2(MAX_HOLD + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   rr_arbiter_4_if.slave    bus
);

   state_t           state_q;
   logic [1:0]       ptr_q;
   logic [1:0]       grant_id_q;
   logic [CNT_W-1:0] hold_cnt_q;
   logic             timeout_q;
   logic [1:0]       pick_d;

   assign pick_d = rr_pick(bus.req, ptr_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         ptr_q      <= 2'd0;
         grant_id_q <= 2'd0;
         hold_cnt_q <= '0;
         timeout_q  <= 1'b0;
      end else begin
         timeout_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.req != '0) begin
                  grant_id_q <= pick_d;
                  // Priority moves past the winner at grant time, so a
                  // revoked requester is already behind the others.
                  ptr_q      <= pick_d + 2'd1;
                  hold_cnt_q <= '0;
                  state_q    <= GRANT;
               end
            end
            GRANT: begin
               // Release is checked first so it wins over the hold limit.
               if (!bus.req[grant_id_q]) begin
                  state_q <= IDLE;
               end else if (hold_cnt_q == CNT_W'(MAX_HOLD - 1)) begin
                  state_q   <= RECOVER;
                  timeout_q <= 1'b1;
               end else begin
                  hold_cnt_q <= hold_cnt_q + CNT_W'(1);
               end
            end
            RECOVER: state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.grant_id = grant_id_q;
   assign bus.busy     = (state_q == GRANT);
   assign bus.timeout  = timeout_q;

   // Decoder inputs are all registered, so grant is clean within a cycle.
   decoder_2to4 u_dec (
      .a_i  (grant_id_q[1]),
      .b_i  (grant_id_q[0]),
      .en_i (state_q == GRANT),
      .y_o  (bus.grant)
   );

endmodule
